// File: rtl/timer_pkg.sv
// Shared types and reset constants for the programmable timer controller.
package timer_pkg;

   typedef enum logic [2:0] {
      OP_NOP            = 3'b000,
      OP_LOAD_PERIOD    = 3'b001,
      OP_LOAD_PRESCALE  = 3'b010,
      OP_START_ONESHOT  = 3'b011,
      OP_START_PERIODIC = 3'b100,
      OP_STOP           = 3'b101,
      OP_CLEAR          = 3'b110,
      OP_RSVD           = 3'b111
   } cmd_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ARM  = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_e;

   typedef enum logic {
      MODE_ONESHOT  = 1'b0,
      MODE_PERIODIC = 1'b1
   } mode_e;

   localparam int PERIOD_RST   = 8'hFF;
   localparam int PRESCALE_RST = 0;

endpackage

// File: rtl/timer_ctrl_if.sv
// Single-cycle command bus into the timer controller.
interface timer_ctrl_if #(parameter int WIDTH = 8);

   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_op;
   logic [WIDTH-1:0] cmd_data;

   modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);

endinterface

// File: rtl/timer_prescaler.sv
// Clock-enable divider: ticks when the running count equals div, then wraps to 0.
module timer_prescaler #(
   parameter int PRESCALE_W = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  en,
   input  logic [PRESCALE_W-1:0] div,
   output logic                  tick
);

   logic [PRESCALE_W-1:0] cnt_q;

   assign tick = en && (cnt_q == div);

   // A count already above a freshly lowered div runs on to the natural wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   cnt_q <= '0;
      else if (clr) cnt_q <= '0;
      else if (en)  cnt_q <= tick ? '0 : cnt_q + PRESCALE_W'(1);
   end

endmodule

// File: rtl/timer_ctrl.sv
// Gated programmable up-counter with one-shot/periodic match sequencing.
//
// state  | meaning
// IDLE   | stopped, count held, commands accepted
// ARM    | one-cycle restart: zero count and prescaler, commands refused
// RUN    | counting on prescaler ticks, compare against period
// DONE   | one-shot completed, count held at period, done high
module timer_ctrl
   import timer_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int PRESCALE_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   timer_ctrl_if.slave      bus,
   output logic [WIDTH-1:0] count,
   output logic             running,
   output logic             match_pulse,
   output logic             done
);

   state_e                state_q, state_d;
   mode_e                 mode_q, mode_d;
   logic [WIDTH-1:0]      period_q, period_d;
   logic [PRESCALE_W-1:0] prescale_q, prescale_d;
   logic [WIDTH-1:0]      count_q, count_d;
   logic                  done_q, done_d;
   logic                  pulse_q, pulse_d;
   logic                  psc_clr, tick;
   logic                  accept, is_start;
   cmd_op_e               op;
   mode_e                 start_mode;

   assign op         = cmd_op_e'(bus.cmd_op);
   assign accept     = bus.cmd_valid && bus.cmd_ready;
   assign is_start   = accept && (op == OP_START_ONESHOT || op == OP_START_PERIODIC);
   assign start_mode = (op == OP_START_PERIODIC) ? MODE_PERIODIC : MODE_ONESHOT;

   timer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (psc_clr),
      .en    (state_q == S_RUN),
      .div   (prescale_q),
      .tick  (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         mode_q     <= MODE_ONESHOT;
         period_q   <= WIDTH'(PERIOD_RST);
         prescale_q <= PRESCALE_W'(PRESCALE_RST);
         count_q    <= '0;
         done_q     <= 1'b0;
         pulse_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         period_q   <= period_d;
         prescale_q <= prescale_d;
         count_q    <= count_d;
         done_q     <= done_d;
         pulse_q    <= pulse_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      period_d   = period_q;
      prescale_d = prescale_q;
      count_d    = count_q;
      done_d     = done_q;
      pulse_d    = 1'b0;
      psc_clr    = 1'b0;

      if (accept && op == OP_LOAD_PERIOD)   period_d   = bus.cmd_data;
      if (accept && op == OP_LOAD_PRESCALE) prescale_d = bus.cmd_data[PRESCALE_W-1:0];

      case (state_q)
         S_IDLE: begin
            if (is_start) begin
               state_d = S_ARM;
               mode_d  = start_mode;
               done_d  = 1'b0;
            end else if (accept && op == OP_CLEAR) begin
               count_d = '0;
               done_d  = 1'b0;
            end
         end
         S_ARM: begin
            count_d = '0;
            psc_clr = 1'b1;
            state_d = S_RUN;
         end
         S_RUN: begin
            if (tick) begin
               if (count_q == period_q) begin
                  pulse_d = 1'b1;
                  if (mode_q == MODE_PERIODIC) begin
                     count_d = '0;
                  end else begin
                     done_d  = 1'b1;
                     state_d = S_DONE;
                  end
               end else begin
                  count_d = count_q + WIDTH'(1);
               end
            end
            // Commands come after the tick so STOP/CLEAR override its state and count.
            if (is_start) begin
               state_d = S_ARM;
               mode_d  = start_mode;
               done_d  = 1'b0;
            end else if (accept && op == OP_STOP) begin
               state_d = S_IDLE;
               psc_clr = 1'b1;
            end else if (accept && op == OP_CLEAR) begin
               count_d = '0;
               done_d  = 1'b0;
            end
         end
         S_DONE: begin
            if (is_start) begin
               state_d = S_ARM;
               mode_d  = start_mode;
               done_d  = 1'b0;
            end else if (accept && op == OP_STOP) begin
               state_d = S_IDLE;
            end else if (accept && op == OP_CLEAR) begin
               state_d = S_IDLE;
               count_d = '0;
               done_d  = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.cmd_ready = (state_q != S_ARM);
   assign running       = (state_q == S_ARM) || (state_q == S_RUN);
   assign count         = count_q;
   assign match_pulse   = pulse_q;
   assign done          = done_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl: hand-computed counts, pulses and flags.
module tb_timer_ctrl;
   import timer_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] count;
   logic       running, match_pulse, done;
   int         n_vec = 0;
   int         n_err = 0;
   int         early;

   timer_ctrl_if #(.WIDTH(8)) bus ();

   timer_ctrl #(.WIDTH(8), .PRESCALE_W(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .count       (count),
      .running     (running),
      .match_pulse (match_pulse),
      .done        (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic cmd(input cmd_op_e o, input logic [7:0] d);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = o;
      bus.cmd_data  = d;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = OP_NOP;
      bus.cmd_data  = 8'h00;
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = OP_NOP;
      bus.cmd_data  = 8'h00;
      #23 rst_n = 1'b1;
      cyc(1);

      // reset and idle
      chk("rst_count", count, 0);
      chk("rst_running", running, 0);
      chk("rst_done", done, 0);
      chk("rst_ready", bus.cmd_ready, 1);
      early = 0;
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         early += match_pulse;
      end
      chk("idle_no_pulse", early, 0);
      chk("idle_count", count, 0);

      // periodic, period 3, prescale 0
      cmd(OP_LOAD_PERIOD, 8'd3);
      cmd(OP_LOAD_PRESCALE, 8'd0);
      cmd(OP_START_PERIODIC, 8'd0);
      chk("arm_ready", bus.cmd_ready, 0);
      chk("arm_running", running, 1);
      for (int i = 0; i < 9; i++) begin
         cyc(1);
         chk($sformatf("per3_count_%0d", i), count, i % 4);
         chk($sformatf("per3_pulse_%0d", i), match_pulse, (i == 4 || i == 8) ? 1 : 0);
      end
      chk("run_ready", bus.cmd_ready, 1);
      cmd(OP_STOP, 8'd0);
      chk("stop_running", running, 0);

      // one-shot, period 2, prescale 2
      cmd(OP_LOAD_PERIOD, 8'd2);
      cmd(OP_LOAD_PRESCALE, 8'd2);
      cmd(OP_START_ONESHOT, 8'd0);
      cyc(1);
      chk("os_start_count", count, 0);
      for (int i = 1; i <= 9; i++) begin
         cyc(1);
         if (i < 9) begin
            chk($sformatf("os_count_%0d", i), count, i / 3);
            chk($sformatf("os_pulse_%0d", i), match_pulse, 0);
            chk($sformatf("os_done_%0d", i), done, 0);
         end else begin
            chk("os_end_count", count, 2);
            chk("os_end_pulse", match_pulse, 1);
            chk("os_end_done", done, 1);
            chk("os_end_running", running, 0);
         end
      end
      cyc(1);
      chk("os_hold_pulse", match_pulse, 0);
      chk("os_hold_done", done, 1);
      chk("os_hold_count", count, 2);
      cmd(OP_CLEAR, 8'd0);
      chk("os_clr_count", count, 0);
      chk("os_clr_done", done, 0);
      chk("os_clr_running", running, 0);

      // period lowered below count mid-run: wrap before matching
      cmd(OP_LOAD_PRESCALE, 8'd0);
      cmd(OP_LOAD_PERIOD, 8'd200);
      cmd(OP_START_PERIODIC, 8'd0);
      cyc(1);
      cyc(150);
      chk("wrap_pre_count", count, 150);
      cmd(OP_LOAD_PERIOD, 8'd100);
      chk("wrap_load_count", count, 151);
      early = 0;
      for (int j = 1; j <= 206; j++) begin
         cyc(1);
         if (j < 206) early += match_pulse;
         if (j == 104) chk("wrap_255", count, 255);
         if (j == 105) chk("wrap_0", count, 0);
         if (j == 205) chk("wrap_100", count, 100);
         if (j == 206) begin
            chk("wrap_match_count", count, 0);
            chk("wrap_match_pulse", match_pulse, 1);
         end
      end
      chk("wrap_no_early", early, 0);
      cmd(OP_STOP, 8'd0);

      // STOP coinciding with a matching tick, periodic
      cmd(OP_LOAD_PERIOD, 8'd5);
      cmd(OP_START_PERIODIC, 8'd0);
      cyc(6);
      chk("sp_pre_count", count, 5);
      cmd(OP_STOP, 8'd0);
      chk("sp_pulse", match_pulse, 1);
      chk("sp_count", count, 0);
      chk("sp_running", running, 0);
      cyc(1);
      chk("sp_pulse_gone", match_pulse, 0);
      cyc(3);
      chk("sp_count_held", count, 0);

      // same in one-shot
      cmd(OP_START_ONESHOT, 8'd0);
      cyc(6);
      cmd(OP_STOP, 8'd0);
      chk("so_pulse", match_pulse, 1);
      chk("so_count", count, 5);
      chk("so_done", done, 1);
      chk("so_running", running, 0);
      chk("so_ready", bus.cmd_ready, 1);
      cyc(2);
      chk("so_count_held", count, 5);
      chk("so_done_held", done, 1);
      cmd(OP_CLEAR, 8'd0);
      chk("so_clr_done", done, 0);

      // period 0 matches on every tick
      cmd(OP_LOAD_PERIOD, 8'd0);
      cmd(OP_START_PERIODIC, 8'd0);
      cyc(1);
      chk("p0_first_pulse", match_pulse, 0);
      for (int i = 1; i <= 3; i++) begin
         cyc(1);
         chk($sformatf("p0_pulse_%0d", i), match_pulse, 1);
         chk($sformatf("p0_count_%0d", i), count, 0);
      end
      cmd(OP_STOP, 8'd0);

      // async reset mid-run, count 7 with prescaler part-way
      cmd(OP_LOAD_PRESCALE, 8'd3);
      cmd(OP_LOAD_PERIOD, 8'd20);
      cmd(OP_START_PERIODIC, 8'd0);
      cyc(1);
      cyc(30);
      chk("mr_pre_count", count, 7);
      rst_n = 1'b0;
      #1;
      chk("mr_count", count, 0);
      chk("mr_running", running, 0);
      chk("mr_done", done, 0);
      chk("mr_pulse", match_pulse, 0);
      chk("mr_ready", bus.cmd_ready, 1);
      #2 rst_n = 1'b1;
      early = 0;
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         early += match_pulse;
      end
      chk("mr_no_pulse", early, 0);
      chk("mr_count_idle", count, 0);

      // reset defaults: prescale 0, period 255
      cmd(OP_START_PERIODIC, 8'd0);
      cyc(2);
      chk("def_prescale_count", count, 1);
      cyc(254);
      chk("def_count_255", count, 255);
      chk("def_no_pulse", match_pulse, 0);
      cyc(1);
      chk("def_wrap_count", count, 0);
      chk("def_wrap_pulse", match_pulse, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
